// File: rtl/mem_region_decoder.sv
// Maps MEM-stage load/store addresses onto data-RAM word indices and byte lanes, and captures faults for the exception unit.
// Latency 1 cycle; no backpressure, so one request is accepted every cycle.
module mem_region_decoder #(
   parameter int                ADDR_W      = 32,
   parameter int                PHYS_W      = 11,
   parameter int                REGION_LOG2 = 12,
   parameter logic [ADDR_W-1:0] GLOBAL_BASE = 32'h10010000,
   parameter logic [ADDR_W-1:0] STACK_BASE  = 32'h7FFFF000,
   parameter bit                CHECK_ALIGN = 1'b1,
   parameter int                CNT_W       = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_size,
   input  logic              fault_clear,
   output logic              rsp_valid,
   output logic [PHYS_W-1:0] rsp_phys_addr,
   output logic [3:0]        rsp_byte_en,
   output logic [1:0]        rsp_region,
   output logic              rsp_fault,
   output logic [1:0]        rsp_cause,
   output logic              fault_sticky,
   output logic [ADDR_W-1:0] fault_addr,
   output logic [1:0]        fault_cause,
   output logic [CNT_W-1:0]  fault_count
);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   localparam logic [1:0] CAUSE_NONE  = 2'd0;
   localparam logic [1:0] CAUSE_UNMAP = 2'd1;
   localparam logic [1:0] CAUSE_ALIGN = 2'd2;
   localparam logic [1:0] CAUSE_SIZE  = 2'd3;

   typedef struct packed {
      logic              vld;
      logic [PHYS_W-1:0] phys;
      logic [3:0]        be;
      logic [1:0]        region;
      logic              fault;
      logic [1:0]        cause;
   } rsp_t;

   logic                   w_hit_glb;
   logic                   w_hit_stk;
   logic [1:0]             w_lane;
   logic [REGION_LOG2-2:0] w_idx;
   logic [3:0]             w_be;
   logic [1:0]             w_cause;
   logic                   w_fault;
   rsp_t                   w_rsp;

   rsp_t                   r_rsp;
   logic                   r_sticky;
   logic [ADDR_W-1:0]      r_faddr;
   logic [1:0]             r_fcause;
   logic [CNT_W-1:0]       r_fcnt;

   assign w_hit_glb = (req_addr[ADDR_W-1:REGION_LOG2] == GLOBAL_BASE[ADDR_W-1:REGION_LOG2]);
   assign w_hit_stk = (req_addr[ADDR_W-1:REGION_LOG2] == STACK_BASE[ADDR_W-1:REGION_LOG2]);
   assign w_lane    = req_addr[1:0];

   // Stack window sits directly above the global one: its index MSB is the stack hit.
   assign w_idx = {w_hit_stk, req_addr[REGION_LOG2-1:2]};

   always_comb begin
      w_be = 4'b0000;
      case (req_size)
         SZ_BYTE: w_be = 4'b0001 << w_lane;
         SZ_HALF: w_be = 4'b0011 << {w_lane[1], 1'b0};
         SZ_WORD: w_be = 4'b1111;
         default: w_be = 4'b0000;
      endcase
   end

   always_comb begin
      w_cause = CAUSE_NONE;
      if (!(w_hit_glb || w_hit_stk)) begin
         w_cause = CAUSE_UNMAP;
      end else if (req_size == SZ_RSVD) begin
         w_cause = CAUSE_SIZE;
      end else if (CHECK_ALIGN &&
                   (((req_size == SZ_HALF) && w_lane[0]) ||
                    ((req_size == SZ_WORD) && (w_lane != 2'b00)))) begin
         w_cause = CAUSE_ALIGN;
      end
   end

   assign w_fault = req_valid && (w_cause != CAUSE_NONE);

   always_comb begin
      w_rsp = '0;
      if (req_valid) begin
         w_rsp.vld = 1'b1;
         if (w_fault) begin
            w_rsp.fault = 1'b1;
            w_rsp.cause = w_cause;
         end else begin
            w_rsp.phys   = PHYS_W'(w_idx);
            w_rsp.be     = w_be;
            w_rsp.region = w_hit_stk ? 2'd2 : 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp <= '0;
      end else begin
         r_rsp <= w_rsp;
      end
   end

   // A fault landing with a clear is treated as the first fault of a fresh window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sticky <= 1'b0;
         r_faddr  <= '0;
         r_fcause <= CAUSE_NONE;
         r_fcnt   <= '0;
      end else if (w_fault) begin
         r_sticky <= 1'b1;
         if (!r_sticky || fault_clear) begin
            r_faddr  <= req_addr;
            r_fcause <= w_cause;
         end
         if (fault_clear) begin
            r_fcnt <= CNT_W'(1);
         end else if (!(&r_fcnt)) begin
            r_fcnt <= r_fcnt + 1'b1;
         end
      end else if (fault_clear) begin
         r_sticky <= 1'b0;
         r_faddr  <= '0;
         r_fcause <= CAUSE_NONE;
         r_fcnt   <= '0;
      end
   end

   assign rsp_valid     = r_rsp.vld;
   assign rsp_phys_addr = r_rsp.phys;
   assign rsp_byte_en   = r_rsp.be;
   assign rsp_region    = r_rsp.region;
   assign rsp_fault     = r_rsp.fault;
   assign rsp_cause     = r_rsp.cause;
   assign fault_sticky  = r_sticky;
   assign fault_addr    = r_faddr;
   assign fault_cause   = r_fcause;
   assign fault_count   = r_fcnt;

endmodule

// File: tb/tb_mem_region_decoder.sv
// Directed bench for mem_region_decoder: one aligned-check instance and one aligning instance share stimulus.
module tb_mem_region_decoder;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic        fault_clear;

   logic        rsp_valid,  na_rsp_valid;
   logic [10:0] rsp_phys_addr, na_rsp_phys_addr;
   logic [3:0]  rsp_byte_en, na_rsp_byte_en;
   logic [1:0]  rsp_region, na_rsp_region;
   logic        rsp_fault, na_rsp_fault;
   logic [1:0]  rsp_cause, na_rsp_cause;
   logic        fault_sticky, na_fault_sticky;
   logic [31:0] fault_addr, na_fault_addr;
   logic [1:0]  fault_cause, na_fault_cause;
   logic [7:0]  fault_count, na_fault_count;

   int n_cmp;
   int n_bad;

   mem_region_decoder u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
      .req_size(req_size), .fault_clear(fault_clear),
      .rsp_valid(rsp_valid), .rsp_phys_addr(rsp_phys_addr), .rsp_byte_en(rsp_byte_en),
      .rsp_region(rsp_region), .rsp_fault(rsp_fault), .rsp_cause(rsp_cause),
      .fault_sticky(fault_sticky), .fault_addr(fault_addr), .fault_cause(fault_cause),
      .fault_count(fault_count)
   );

   mem_region_decoder #(.CHECK_ALIGN(1'b0)) u_dut_na (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
      .req_size(req_size), .fault_clear(fault_clear),
      .rsp_valid(na_rsp_valid), .rsp_phys_addr(na_rsp_phys_addr), .rsp_byte_en(na_rsp_byte_en),
      .rsp_region(na_rsp_region), .rsp_fault(na_rsp_fault), .rsp_cause(na_rsp_cause),
      .fault_sticky(na_fault_sticky), .fault_addr(na_fault_addr), .fault_cause(na_fault_cause),
      .fault_count(na_fault_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_rsp(input string tag, input logic v, input logic [10:0] phys,
                            input logic [3:0] be, input logic [1:0] region,
                            input logic flt, input logic [1:0] cause);
      check_eq({tag, ".vld"},    32'(rsp_valid),     32'(v));
      check_eq({tag, ".phys"},   32'(rsp_phys_addr), 32'(phys));
      check_eq({tag, ".be"},     32'(rsp_byte_en),   32'(be));
      check_eq({tag, ".region"}, 32'(rsp_region),    32'(region));
      check_eq({tag, ".fault"},  32'(rsp_fault),     32'(flt));
      check_eq({tag, ".cause"},  32'(rsp_cause),     32'(cause));
   endtask

   task automatic check_cap(input string tag, input logic st, input logic [31:0] addr,
                            input logic [1:0] cause, input logic [7:0] cnt);
      check_eq({tag, ".sticky"}, 32'(fault_sticky), 32'(st));
      check_eq({tag, ".faddr"},  fault_addr,        addr);
      check_eq({tag, ".fcause"}, 32'(fault_cause),  32'(cause));
      check_eq({tag, ".fcount"}, 32'(fault_count),  32'(cnt));
   endtask

   // Drive one request across one rising edge, sample 1 time unit after it, then go idle.
   task automatic cycle(input logic v, input logic [31:0] addr, input logic [1:0] size,
                        input logic clr);
      req_valid   = v;
      req_addr    = addr;
      req_size    = size;
      fault_clear = clr;
      @(posedge clk);
      #1;
      req_valid   = 1'b0;
      fault_clear = 1'b0;
   endtask

   initial begin
      n_cmp       = 0;
      n_bad       = 0;
      rst_n       = 1'b0;
      req_valid   = 1'b0;
      req_addr    = '0;
      req_size    = 2'b00;
      fault_clear = 1'b0;

      #1;
      check_rsp("reset", 1'b0, 11'd0, 4'h0, 2'd0, 1'b0, 2'd0);
      check_cap("reset", 1'b0, 32'h0, 2'd0, 8'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      req_valid = 1'b1; req_addr = 32'h10010000; req_size = 2'b10;
      #1;
      check_eq("lat_pre.vld", 32'(rsp_valid), 32'd0);
      cycle(1'b1, 32'h10010000, 2'b10, 1'b0);
      check_rsp("glb_lo", 1'b1, 11'd0, 4'hF, 2'd1, 1'b0, 2'd0);
      cycle(1'b1, 32'h10010FFC, 2'b10, 1'b0);
      check_rsp("glb_hi", 1'b1, 11'd1023, 4'hF, 2'd1, 1'b0, 2'd0);
      cycle(1'b1, 32'h10010FFF, 2'b00, 1'b0);
      check_rsp("glb_end", 1'b1, 11'd1023, 4'h8, 2'd1, 1'b0, 2'd0);
      cycle(1'b1, 32'h7FFFF000, 2'b10, 1'b0);
      check_rsp("stk_lo", 1'b1, 11'd1024, 4'hF, 2'd2, 1'b0, 2'd0);
      cycle(1'b1, 32'h7FFFFFFC, 2'b10, 1'b0);
      check_rsp("stk_hi", 1'b1, 11'd2047, 4'hF, 2'd2, 1'b0, 2'd0);
      cycle(1'b1, 32'h10010003, 2'b00, 1'b0);
      check_rsp("byte3", 1'b1, 11'd0, 4'h8, 2'd1, 1'b0, 2'd0);
      cycle(1'b1, 32'h10010006, 2'b01, 1'b0);
      check_rsp("half6", 1'b1, 11'd1, 4'hC, 2'd1, 1'b0, 2'd0);
      check_cap("no_fault", 1'b0, 32'h0, 2'd0, 8'd0);

      cycle(1'b1, 32'h10010005, 2'b01, 1'b0);
      check_rsp("half5", 1'b1, 11'd0, 4'h0, 2'd0, 1'b1, 2'd2);
      check_cap("half5", 1'b1, 32'h10010005, 2'd2, 8'd1);
      check_eq("na_half5.be",    32'(na_rsp_byte_en),   32'h3);
      check_eq("na_half5.fault", 32'(na_rsp_fault),     32'd0);
      check_eq("na_half5.phys",  32'(na_rsp_phys_addr), 32'd1);
      check_eq("na_half5.sticky", 32'(na_fault_sticky), 32'd0);

      cycle(1'b0, 32'h0, 2'b00, 1'b0);
      check_rsp("idle", 1'b0, 11'd0, 4'h0, 2'd0, 1'b0, 2'd0);
      cycle(1'b0, 32'h0, 2'b00, 1'b1);
      check_cap("clear", 1'b0, 32'h0, 2'd0, 8'd0);

      cycle(1'b1, 32'h10011000, 2'b10, 1'b0);
      check_rsp("unmap_hi", 1'b1, 11'd0, 4'h0, 2'd0, 1'b1, 2'd1);
      cycle(1'b1, 32'h1000FFFF, 2'b00, 1'b0);
      check_rsp("unmap_lo", 1'b1, 11'd0, 4'h0, 2'd0, 1'b1, 2'd1);
      cycle(1'b1, 32'h10010000, 2'b11, 1'b0);
      check_rsp("rsvd", 1'b1, 11'd0, 4'h0, 2'd0, 1'b1, 2'd3);
      check_eq("na_rsvd.cause", 32'(na_rsp_cause), 32'd3);
      cycle(1'b1, 32'h00000002, 2'b10, 1'b0);
      check_rsp("prio", 1'b1, 11'd0, 4'h0, 2'd0, 1'b1, 2'd1);
      check_cap("after4", 1'b1, 32'h10011000, 2'd1, 8'd4);

      cycle(1'b0, 32'h0, 2'b00, 1'b1);
      cycle(1'b1, 32'h00000000, 2'b10, 1'b0);
      cycle(1'b1, 32'h20000000, 2'b10, 1'b0);
      check_cap("first_wins", 1'b1, 32'h00000000, 2'd1, 8'd2);

      cycle(1'b1, 32'h00001000, 2'b10, 1'b1);
      check_cap("clr_collide", 1'b1, 32'h00001000, 2'd1, 8'd1);

      req_valid = 1'b1; req_addr = 32'h00000000; req_size = 2'b10;
      for (int i = 0; i < 300; i++) @(posedge clk);
      #1;
      check_cap("saturate", 1'b1, 32'h00001000, 2'd1, 8'd255);

      // Reset between edges with a request pending on the inputs.
      req_addr = 32'h10010000;
      #2;
      rst_n = 1'b0;
      #1;
      check_rsp("arst", 1'b0, 11'd0, 4'h0, 2'd0, 1'b0, 2'd0);
      check_cap("arst", 1'b0, 32'h0, 2'd0, 8'd0);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_eq("arst_drop.vld", 32'(rsp_valid), 32'd0);
      cycle(1'b1, 32'h7FFFF004, 2'b10, 1'b0);
      check_rsp("post_rst", 1'b1, 11'd1025, 4'hF, 2'd2, 1'b0, 2'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
